de0_nano_gpio_pio: RTL and testbench

DE0_NANO_GPIO_PIO -- requirements
Module: de0_nano_gpio_pio

---
 rtl/de0_nano_gpio_pio.sv | 125 ++++++++++++
 tb/tb_de0_nano_gpio_pio.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/de0_nano_gpio_pio.sv
// rtl/de0_nano_gpio_pio.sv - Avalon-MM GPIO block with direction, set/clear and edge-capture interrupt
module de0_nano_gpio_pio #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] in_meta;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_clear;
    logic             wr_en;
    logic             unused_ok;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    // Bits of writedata beyond WIDTH are deliberately ignored.
    assign unused_ok = &{1'b0, writedata};

    // Two-flop synchroniser for the external inputs, plus one history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_meta <= '0;
            in_sync <= '0;
            in_prev <= '0;
        end else begin
            in_meta <= in_port;
            in_sync <= in_meta;
            in_prev <= in_sync;
        end
    end

    // Select the edge polarity that arms a capture bit.
    always_comb begin
        edge_hit = in_sync ^ in_prev;
        if (EDGE_TYPE == 0) begin
            edge_hit = in_sync & ~in_prev;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = ~in_sync & in_prev;
        end
    end

    // Output data register: direct write, bitwise set and bitwise clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE[WIDTH-1:0];
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_out <= wdata;
                ADDR_OUTSET: data_out <= data_out | wdata;
                ADDR_OUTCLR: data_out <= data_out & ~wdata;
                default:     data_out <= data_out;
            endcase
        end
    end

    // Direction and interrupt mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir  <= '0;
            mask <= '0;
        end else if (wr_en) begin
            if (address == ADDR_DIR) begin
                dir <= wdata;
            end
            if (address == ADDR_IRQMASK) begin
                mask <= wdata;
            end
        end
    end

    assign cap_clear = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

    // Sticky edge capture; a new edge overrides a simultaneous write-one-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~cap_clear) | edge_hit;
        end
    end

    // Zero-latency read mux; output-enabled bits read back the driven value.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = (data_out & dir) | (in_sync & ~dir);
            ADDR_DIR:     readdata[WIDTH-1:0] = dir;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = mask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:      readdata = '0;
        endcase
    end

    assign out_port = data_out;
    assign out_en   = dir;
    assign irq      = |(edgecap & mask);

endmodule

// File: tb/tb_de0_nano_gpio_pio.sv
// tb/tb_de0_nano_gpio_pio.sv - directed self-checking bench for de0_nano_gpio_pio
module tb_de0_nano_gpio_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd2;
    logic [7:0]  out0, out2, en0, en2;
    logic        irq0, irq2;

    int passed = 0;
    int total  = 0;

    // Rising-edge capture, default reset value.
    de0_nano_gpio_pio #(.WIDTH(8), .RESET_VALUE(32'h0), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .out_port(out0), .out_en(en0), .irq(irq0)
    );

    // Any-edge capture, non-zero reset value.
    de0_nano_gpio_pio #(.WIDTH(8), .RESET_VALUE(32'h3C), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in_port), .out_port(out2), .out_en(en2), .irq(irq2)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a,
                      input logic [31:0] exp0, input logic [31:0] exp2);
        address = a;
        #1;
        check({tag, "_dut0"}, rd0, exp0);
        check({tag, "_dut2"}, rd2, exp2);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0", {24'h0, out0}, 32'h00);
        check("rst_out2", {24'h0, out2}, 32'h3C);
        check("rst_en0", {24'h0, en0}, 32'h00);
        check("rst_irq0", {31'h0, irq0}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Data, set and clear.
        wr(3'd0, 32'h0F);
        check("data_0f", {24'h0, out0}, 32'h0F);
        wr(3'd4, 32'hF0);
        check("outset_ff", {24'h0, out0}, 32'hFF);
        wr(3'd5, 32'h81);
        check("outclr_7e", {24'h0, out0}, 32'h7E);
        rd("rd_outset", 3'd4, 32'h0, 32'h0);
        rd("rd_outclr", 3'd5, 32'h0, 32'h0);
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'hFF);
        check("rsv_out", {24'h0, out0}, 32'h7E);
        check("rsv_en", {24'h0, en0}, 32'h00);
        rd("rd_rsv6", 3'd6, 32'h0, 32'h0);
        rd("rd_rsv7", 3'd7, 32'h0, 32'h0);

        // Direction mix: upper nibble driven, lower nibble from pins.
        wr(3'd1, 32'hF0);
        check("dir_en", {24'h0, en0}, 32'hF0);
        wr(3'd0, 32'hFFFF_FFA0);
        in_port = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        rd("dir_mix", 3'd0, 32'hA5, 32'hA5);
        rd("rd_dir", 3'd1, 32'hF0, 32'hF0);
        rd("cap_05", 3'd3, 32'h05, 32'h05);
        wr(3'd3, 32'hFF);
        rd("cap_clr", 3'd3, 32'h00, 32'h00);

        // Falling edge on bit 0: ignored by rising-only, seen by any-edge.
        wr(3'd2, 32'h01);
        rd("rd_mask", 3'd2, 32'h01, 32'h01);
        in_port = 8'h04;
        repeat (4) @(posedge clk);
        #1;
        rd("fall_only", 3'd3, 32'h00, 32'h01);
        wr(3'd3, 32'hFF);

        // Rising edge on bit 0: three-edge latency to capture and irq.
        in_port = 8'h05;
        repeat (2) @(posedge clk);
        #1;
        check("lat2_irq", {31'h0, irq0}, 32'h0);
        rd("lat2_cap", 3'd3, 32'h00, 32'h00);
        @(posedge clk);
        #1;
        check("lat3_irq", {31'h0, irq0}, 32'h1);
        rd("lat3_cap", 3'd3, 32'h01, 32'h01);
        wr(3'd3, 32'h01);
        check("irq_clr0", {31'h0, irq0}, 32'h0);
        check("irq_clr2", {31'h0, irq2}, 32'h0);

        // Edge on bit 2 lands on the same edge as its clear.
        in_port = 8'h01;
        repeat (4) @(posedge clk);
        wr(3'd3, 32'hFF);
        in_port = 8'h05;
        repeat (2) @(posedge clk);
        wr(3'd3, 32'h04);
        rd("collide", 3'd3, 32'h04, 32'h04);

        // Mask zero, all bits toggle (dir does not gate detection).
        wr(3'd2, 32'h00);
        wr(3'd3, 32'hFF);
        in_port = 8'hFA;
        repeat (4) @(posedge clk);
        #1;
        rd("all_edge", 3'd3, 32'hFA, 32'hFF);
        check("mask0_irq0", {31'h0, irq0}, 32'h0);
        check("mask0_irq2", {31'h0, irq2}, 32'h0);
        wr(3'd3, 32'hFF);
        in_port = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        rd("all_fall", 3'd3, 32'h00, 32'hFA);

        // Reset in the middle of operation.
        wr(3'd0, 32'hA5);
        wr(3'd1, 32'hFF);
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h0F);
        in_port = 8'h0F;
        repeat (3) @(posedge clk);
        #1;
        rd("pre_rst_cap", 3'd3, 32'h0F, 32'h0F);
        check("pre_rst_irq", {31'h0, irq0}, 32'h1);
        check("pre_rst_out", {24'h0, out0}, 32'hA5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out0", {24'h0, out0}, 32'h00);
        check("arst_out2", {24'h0, out2}, 32'h3C);
        check("arst_en", {24'h0, en0}, 32'h00);
        check("arst_irq", {31'h0, irq0}, 32'h0);
        check("arst_cap", rd0, 32'h00);

        // Write during reset is discarded.
        wr(3'd0, 32'h55);
        check("rst_wr", {24'h0, out0}, 32'h00);

        // Held-high input after reset registers as a rising edge.
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rd("post_rst_2", 3'd3, 32'h00, 32'h00);
        @(posedge clk);
        #1;
        rd("post_rst_3", 3'd3, 32'h0F, 32'h0F);
        check("post_rst_irq", {31'h0, irq0}, 32'h0);
        rd("post_rst_data", 3'd0, 32'h0F, 32'h0F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
